// File: rtl/rgmii_udp_rx.sv
// rgmii_udp_rx: receive-side Ethernet/IPv4/UDP parser on the recovered GMII byte stream.
// Strips preamble/SFD, parses the 42-byte header, filters on destination, streams the
// UDP payload on AXI-Stream (no backpressure) and reports a per-frame verdict.
//   clk_i, arstn_i                  : byte clock, async active-low reset
//   rx_data_i/rx_dv_i/rx_er_i       : GMII-style receive byte stream
//   check_destination_i, fpga_*_i   : destination filter control and own addresses
//   m_axis_tdata/tvalid/tlast_o     : payload stream, one byte per cycle
//   frame_done_o/frame_ok_o         : end-of-frame pulse and its good/bad qualifier
//   crc_err_o                       : FCS failure pulse
//   host_mac/ip/port_o              : source addresses of the last accepted frame
module rgmii_udp_rx #(
    parameter int unsigned MAX_PAYLOAD = 1472
) (
    input  logic        clk_i,
    input  logic        arstn_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_dv_i,
    input  logic        rx_er_i,
    input  logic        check_destination_i,
    input  logic [47:0] fpga_mac_i,
    input  logic [31:0] fpga_ip_i,
    input  logic [15:0] fpga_port_i,
    output logic [7:0]  m_axis_tdata_o,
    output logic        m_axis_tvalid_o,
    output logic        m_axis_tlast_o,
    output logic        frame_done_o,
    output logic        frame_ok_o,
    output logic        crc_err_o,
    output logic [47:0] host_mac_o,
    output logic [31:0] host_ip_o,
    output logic [15:0] host_port_o
);

    // The 42nd header byte is still on rx_data_i when the header is judged, so only
    // 41 bytes are stored; byte i sits at bits [(HDR_BYTES-i)*8-1 -: 8].
    localparam int unsigned HDR_BYTES = 41;
    localparam int unsigned HDR_W     = HDR_BYTES * 8;
    localparam int unsigned LEN_W     = 16;
    localparam int unsigned CNT_W     = 6;
    localparam int unsigned TAIL_W    = 3;
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    localparam int unsigned DMAC_MSB  = (HDR_BYTES - 0) * 8 - 1;
    localparam int unsigned SMAC_MSB  = (HDR_BYTES - 6) * 8 - 1;
    localparam int unsigned ETYPE_MSB = (HDR_BYTES - 12) * 8 - 1;
    localparam int unsigned VIHL_MSB  = (HDR_BYTES - 14) * 8 - 1;
    localparam int unsigned PROTO_MSB = (HDR_BYTES - 23) * 8 - 1;
    localparam int unsigned SIP_MSB   = (HDR_BYTES - 26) * 8 - 1;
    localparam int unsigned DIP_MSB   = (HDR_BYTES - 30) * 8 - 1;
    localparam int unsigned SPORT_MSB = (HDR_BYTES - 34) * 8 - 1;
    localparam int unsigned DPORT_MSB = (HDR_BYTES - 36) * 8 - 1;
    localparam int unsigned ULEN_MSB  = (HDR_BYTES - 38) * 8 - 1;

    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_HEADER, S_PAYLOAD, S_TAIL, S_DROP
    } state_e;

    state_e              state_q, state_d;
    logic [HDR_W-1:0]    hdr_q, hdr_d;
    logic [CNT_W-1:0]    hdr_cnt_q, hdr_cnt_d;
    logic [LEN_W-1:0]    pay_len_q, pay_len_d;
    logic [LEN_W-1:0]    pay_cnt_q, pay_cnt_d;
    logic [TAIL_W-1:0]   tail_cnt_q, tail_cnt_d;
    logic [31:0]         crc_q, crc_d;
    logic                err_q, err_d;
    logic [7:0]          tdata_q, tdata_d;
    logic                tvalid_q, tvalid_d;
    logic                tlast_q, tlast_d;
    logic                done_q, done_d;
    logic                ok_q, ok_d;
    logic                crc_err_q, crc_err_d;
    logic [47:0]         host_mac_q, host_mac_d;
    logic [31:0]         host_ip_q, host_ip_d;
    logic [15:0]         host_port_q, host_port_d;

    logic [LEN_W-1:0]    udp_len_c;
    logic                hdr_ok_c;
    logic                fcs_good_c;

    // Byte-parallel reflected CRC-32 update (no final inversion).
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r >> 1) ^ (((r[0] ^ d[i]) == 1'b1) ? CRC_POLY : 32'h0);
        end
        return r;
    endfunction

    // Header acceptance on the stored bytes (fields are in wire order).
    always_comb begin
        logic mac_ok;
        logic dest_ok;
        udp_len_c = hdr_q[ULEN_MSB -: 16];
        mac_ok    = (hdr_q[DMAC_MSB -: 48] == fpga_mac_i) || (hdr_q[DMAC_MSB -: 48] == 48'hFFFF_FFFF_FFFF);
        dest_ok   = mac_ok && (hdr_q[DIP_MSB -: 32] == fpga_ip_i) && (hdr_q[DPORT_MSB -: 16] == fpga_port_i);
        hdr_ok_c  = (hdr_q[ETYPE_MSB -: 16] == 16'h0800) &&
                    (hdr_q[VIHL_MSB -: 8] == 8'h45) &&
                    (hdr_q[PROTO_MSB -: 8] == 8'h11) &&
                    (udp_len_c >= LEN_W'(8)) &&
                    (udp_len_c <= LEN_W'(MAX_PAYLOAD + 8)) &&
                    (!check_destination_i || dest_ok);
    end

    // A frame with fewer than 4 tail bytes has no complete FCS.
    assign fcs_good_c = (crc_q == CRC_RESIDUE) && (tail_cnt_q == TAIL_W'(4));

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        hdr_d       = hdr_q;
        hdr_cnt_d   = hdr_cnt_q;
        pay_len_d   = pay_len_q;
        pay_cnt_d   = pay_cnt_q;
        tail_cnt_d  = tail_cnt_q;
        crc_d       = crc_q;
        err_d       = err_q;
        tdata_d     = tdata_q;
        tvalid_d    = 1'b0;
        tlast_d     = 1'b0;
        done_d      = 1'b0;
        ok_d        = 1'b0;
        crc_err_d   = 1'b0;
        host_mac_d  = host_mac_q;
        host_ip_d   = host_ip_q;
        host_port_d = host_port_q;

        if (state_q != S_IDLE && rx_er_i) begin
            err_d = 1'b1;
        end
        if (rx_dv_i && (state_q inside {S_HEADER, S_PAYLOAD, S_TAIL})) begin
            crc_d = crc_byte(crc_q, rx_data_i);
        end

        case (state_q)
            S_IDLE: begin
                err_d = 1'b0;
                if (rx_dv_i) begin
                    state_d = (rx_data_i == 8'h55) ? S_PREAMBLE : S_DROP;
                end
            end
            S_PREAMBLE: begin
                if (!rx_dv_i) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (rx_data_i == 8'hD5) begin
                    hdr_cnt_d = '0;
                    crc_d     = 32'hFFFF_FFFF;
                    state_d   = S_HEADER;
                end else if (rx_data_i != 8'h55) begin
                    state_d = S_DROP;
                end
            end
            S_HEADER: begin
                if (!rx_dv_i) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (hdr_cnt_q == CNT_W'(HDR_BYTES)) begin
                    pay_len_d  = udp_len_c - LEN_W'(8);
                    pay_cnt_d  = '0;
                    tail_cnt_d = '0;
                    if (!hdr_ok_c) begin
                        state_d = S_DROP;
                    end else if (udp_len_c == LEN_W'(8)) begin
                        state_d = S_TAIL;
                    end else begin
                        state_d = S_PAYLOAD;
                    end
                end else begin
                    hdr_d     = {hdr_q[HDR_W-9:0], rx_data_i};
                    hdr_cnt_d = hdr_cnt_q + CNT_W'(1);
                end
            end
            S_PAYLOAD: begin
                if (!rx_dv_i) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tdata_d   = rx_data_i;
                    tvalid_d  = 1'b1;
                    pay_cnt_d = pay_cnt_q + LEN_W'(1);
                    if (pay_cnt_q == pay_len_q - LEN_W'(1)) begin
                        tlast_d = 1'b1;
                        state_d = S_TAIL;
                    end
                end
            end
            S_TAIL: begin
                if (rx_dv_i) begin
                    if (tail_cnt_q != TAIL_W'(4)) begin
                        tail_cnt_d = tail_cnt_q + TAIL_W'(1);
                    end
                end else begin
                    done_d    = 1'b1;
                    ok_d      = fcs_good_c && !err_q;
                    crc_err_d = !fcs_good_c;
                    if (fcs_good_c && !err_q) begin
                        host_mac_d  = hdr_q[SMAC_MSB -: 48];
                        host_ip_d   = hdr_q[SIP_MSB -: 32];
                        host_port_d = hdr_q[SPORT_MSB -: 16];
                    end
                    state_d = S_IDLE;
                end
            end
            S_DROP: begin
                if (!rx_dv_i) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q     <= S_IDLE;
            hdr_q       <= '0;
            hdr_cnt_q   <= '0;
            pay_len_q   <= '0;
            pay_cnt_q   <= '0;
            tail_cnt_q  <= '0;
            crc_q       <= 32'hFFFF_FFFF;
            err_q       <= 1'b0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            done_q      <= 1'b0;
            ok_q        <= 1'b0;
            crc_err_q   <= 1'b0;
            host_mac_q  <= '0;
            host_ip_q   <= '0;
            host_port_q <= '0;
        end else begin
            state_q     <= state_d;
            hdr_q       <= hdr_d;
            hdr_cnt_q   <= hdr_cnt_d;
            pay_len_q   <= pay_len_d;
            pay_cnt_q   <= pay_cnt_d;
            tail_cnt_q  <= tail_cnt_d;
            crc_q       <= crc_d;
            err_q       <= err_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            done_q      <= done_d;
            ok_q        <= ok_d;
            crc_err_q   <= crc_err_d;
            host_mac_q  <= host_mac_d;
            host_ip_q   <= host_ip_d;
            host_port_q <= host_port_d;
        end
    end

    assign m_axis_tdata_o  = tdata_q;
    assign m_axis_tvalid_o = tvalid_q;
    // A truncated frame is only known once rx_dv_i drops, which is the same cycle the
    // previous byte is on the bus, so tlast is forced on that beat directly.
    assign m_axis_tlast_o  = tlast_q || (tvalid_q && (state_q == S_PAYLOAD) && !rx_dv_i);
    assign frame_done_o    = done_q;
    assign frame_ok_o      = ok_q;
    assign crc_err_o       = crc_err_q;
    assign host_mac_o      = host_mac_q;
    assign host_ip_o       = host_ip_q;
    assign host_port_o     = host_port_q;

endmodule

// File: tb/tb_rgmii_udp_rx.sv
// tb_rgmii_udp_rx: directed frames into rgmii_udp_rx; expected beats and verdicts are
// queued by the stimulus and checked by an independent monitor.
module tb_rgmii_udp_rx;

    localparam logic [47:0] FPGA_MAC  = 48'h02_00_00_00_00_01;
    localparam logic [31:0] FPGA_IP   = 32'hC0_A8_01_0A;
    localparam logic [15:0] FPGA_PORT = 16'd5000;
    localparam logic [47:0] HOST_MAC  = 48'h02_11_22_33_44_55;
    localparam logic [31:0] HOST_IP   = 32'hC0_A8_01_14;
    localparam logic [15:0] HOST_PORT = 16'h1234;

    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_dv = 1'b0;
    logic        rx_er = 1'b0;
    logic        check_dest = 1'b1;
    logic [7:0]  tdata;
    logic        tvalid, tlast, frame_done, frame_ok, crc_err;
    logic [47:0] host_mac;
    logic [31:0] host_ip;
    logic [15:0] host_port;

    int checks = 0;
    int errors = 0;

    logic [7:0] frm[$];
    logic [8:0] exp_beats[$];   // {last, data}
    logic [1:0] exp_verd[$];    // {ok, crc_err}

    rgmii_udp_rx dut (
        .clk_i               (clk),
        .arstn_i             (arstn),
        .rx_data_i           (rx_data),
        .rx_dv_i             (rx_dv),
        .rx_er_i             (rx_er),
        .check_destination_i (check_dest),
        .fpga_mac_i          (FPGA_MAC),
        .fpga_ip_i           (FPGA_IP),
        .fpga_port_i         (FPGA_PORT),
        .m_axis_tdata_o      (tdata),
        .m_axis_tvalid_o     (tvalid),
        .m_axis_tlast_o      (tlast),
        .frame_done_o        (frame_done),
        .frame_ok_o          (frame_ok),
        .crc_err_o           (crc_err),
        .host_mac_o          (host_mac),
        .host_ip_o           (host_ip),
        .host_port_o         (host_port)
    );

    always #4 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: compares every beat and every verdict against the queues.
    always @(negedge clk) begin
        logic [8:0] eb;
        logic [1:0] ev;
        if (tvalid) begin
            checks++;
            if (exp_beats.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected: got data %h last %b, none expected", tdata, tlast);
            end else begin
                eb = exp_beats.pop_front();
                if ({tlast, tdata} !== eb) begin
                    errors++;
                    $display("FAIL beat: got data %h last %b expected data %h last %b", tdata, tlast, eb[7:0], eb[8]);
                end
            end
        end
        if (frame_done) begin
            checks++;
            if (exp_verd.size() == 0) begin
                errors++;
                $display("FAIL verdict_unexpected: got ok %b crc_err %b, none expected", frame_ok, crc_err);
            end else begin
                ev = exp_verd.pop_front();
                if ({frame_ok, crc_err} !== ev) begin
                    errors++;
                    $display("FAIL verdict: got ok %b crc_err %b expected ok %b crc_err %b", frame_ok, crc_err, ev[1], ev[0]);
                end
            end
        end
        if (crc_err && !frame_done) begin
            checks++;
            errors++;
            $display("FAIL crc_err_alone: crc_err %b while frame_done %b", crc_err, frame_done);
        end
    end

    task automatic push_n(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) frm.push_back(v[i*8 +: 8]);
    endtask

    // Builds header + DE AD BE EF + 14 pad bytes + FCS (LSB first) into frm.
    task automatic build(input logic [47:0] dmac, input logic [15:0] etype, input logic [15:0] dport);
        logic [31:0] c;
        logic [7:0]  b;
        frm.delete();
        push_n(64'(dmac), 6);
        push_n(64'(HOST_MAC), 6);
        push_n(64'(etype), 2);
        push_n(64'h4500, 2);
        push_n(64'd32, 2);
        push_n(64'h0000, 2);
        push_n(64'h4000, 2);
        push_n(64'h4011, 2);
        push_n(64'h0000, 2);
        push_n(64'(HOST_IP), 4);
        push_n(64'(FPGA_IP), 4);
        push_n(64'(HOST_PORT), 2);
        push_n(64'(dport), 2);
        push_n(64'd12, 2);
        push_n(64'h0000, 2);
        push_n(64'hDEADBEEF, 4);
        for (int i = 0; i < 14; i++) frm.push_back(8'h00);
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < frm.size(); i++) begin
            b = frm[i];
            c = c ^ {24'h0, b};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        c = ~c;
        for (int i = 0; i < 4; i++) frm.push_back(c[i*8 +: 8]);
    endtask

    task automatic expect_payload(input int n);
        logic [31:0] p;
        p = 32'hDEADBEEF;
        for (int i = 0; i < n; i++) exp_beats.push_back({(i == n - 1), p[31 - i*8 -: 8]});
    endtask

    task automatic expect_verdict(input logic ok, input logic ce);
        exp_verd.push_back({ok, ce});
    endtask

    task automatic send_preamble();
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            rx_dv   = 1'b1;
            rx_data = (i == 7) ? 8'hD5 : 8'h55;
        end
    endtask

    // Sends preamble, the first nbytes of frm, then holds rx_dv low for ipg cycles.
    task automatic send(input int nbytes, input int ipg);
        send_preamble();
        for (int i = 0; i < nbytes; i++) begin
            @(posedge clk); #1;
            rx_data = frm[i];
        end
        @(posedge clk); #1;
        rx_dv   = 1'b0;
        rx_data = '0;
        repeat (ipg - 1) @(posedge clk);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs", 128'({tdata, tvalid, tlast, frame_done, frame_ok, crc_err, host_mac, host_ip, host_port}), 128'(0));
        @(posedge clk); #1;
        arstn = 1'b1;
        repeat (3) @(posedge clk);

        // Accepted frame
        build(FPGA_MAC, 16'h0800, FPGA_PORT);
        expect_payload(4); expect_verdict(1'b1, 1'b0);
        send(frm.size(), 12);
        chk("host_ip", 128'(host_ip), 128'(HOST_IP));
        chk("host_mac", 128'(host_mac), 128'(HOST_MAC));
        chk("host_port", 128'(host_port), 128'(HOST_PORT));

        // Corrupted last FCS byte
        build(FPGA_MAC, 16'h0800, FPGA_PORT);
        frm[frm.size() - 1] = frm[frm.size() - 1] ^ 8'hFF;
        expect_payload(4); expect_verdict(1'b0, 1'b1);
        send(frm.size(), 12);

        // Wrong destination port, filter on then off
        build(FPGA_MAC, 16'h0800, 16'd5001);
        expect_verdict(1'b0, 1'b0);
        send(frm.size(), 12);
        check_dest = 1'b0;
        expect_payload(4); expect_verdict(1'b1, 1'b0);
        send(frm.size(), 12);
        check_dest = 1'b1;

        // Broadcast destination MAC
        build(48'hFFFF_FFFF_FFFF, 16'h0800, FPGA_PORT);
        expect_payload(4); expect_verdict(1'b1, 1'b0);
        send(frm.size(), 12);

        // Truncated after two payload bytes
        build(FPGA_MAC, 16'h0800, FPGA_PORT);
        expect_payload(2); expect_verdict(1'b0, 1'b0);
        send(44, 12);

        // ARP ethertype dropped, then a good frame after a 12-cycle gap
        build(FPGA_MAC, 16'h0806, FPGA_PORT);
        expect_verdict(1'b0, 1'b0);
        send(frm.size(), 12);
        build(FPGA_MAC, 16'h0800, FPGA_PORT);
        expect_payload(4); expect_verdict(1'b1, 1'b0);
        send(frm.size(), 12);

        // Reset in the first payload byte; remainder of that frame is dropped
        build(FPGA_MAC, 16'h0800, FPGA_PORT);
        send_preamble();
        for (int i = 0; i < 42; i++) begin
            @(posedge clk); #1;
            rx_data = frm[i];
        end
        @(posedge clk); #1;
        rx_data = frm[42];
        #2 arstn = 1'b0;
        @(posedge clk); #1;
        rx_data = frm[43];
        chk("reset_mid_outputs", 128'({tvalid, frame_done, host_ip}), 128'(0));
        @(posedge clk); #1;
        rx_data = frm[44];
        #2 arstn = 1'b1;
        expect_verdict(1'b0, 1'b0);
        for (int i = 45; i < frm.size(); i++) begin
            @(posedge clk); #1;
            rx_data = frm[i];
        end
        @(posedge clk); #1;
        rx_dv   = 1'b0;
        rx_data = '0;
        repeat (11) @(posedge clk);

        // Fresh frame after reset
        expect_payload(4); expect_verdict(1'b1, 1'b0);
        send(frm.size(), 12);
        chk("host_ip_after_reset", 128'(host_ip), 128'(HOST_IP));

        for (int i = 0; i < 200 && (exp_beats.size() != 0 || exp_verd.size() != 0); i++) @(posedge clk);
        chk("beats_drained", 128'(exp_beats.size()), 128'(0));
        chk("verdicts_drained", 128'(exp_verd.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rgmii_udp_rx.md
Name: rgmii_udp_rx

Overview:
- Receive-side Ethernet/IPv4/UDP frame parser; mirror of the UDP transmit framer.
- Takes the GMII-style byte stream recovered from the RGMII DDR input stage and strips preamble/SFD.
- Parses the 42-byte Ethernet+IPv4+UDP header, filters on destination MAC/IP/port, and emits the UDP payload as an AXI-Stream byte stream.
- Checks the FCS and reports the per-frame verdict on sideband pulses.

Parameters:
- MAX_PAYLOAD, 1472, largest accepted UDP payload in bytes; larger UDP length drops the frame.

Ports:
- clk_i  in  1  RX byte clock (125 MHz GMII-equivalent).
- arstn_i  in  1  asynchronous active-low reset.
- rx_data_i  in  8  received byte.
- rx_dv_i  in  1  data valid; high for the whole frame including preamble.
- rx_er_i  in  1  PHY receive error.
- check_destination_i  in  1  enable destination filtering (control register bit).
- fpga_mac_i  in  48  own MAC, byte 0 = first byte on the wire.
- fpga_ip_i  in  32  own IP, byte 0 = first on the wire.
- fpga_port_i  in  16  own UDP port.
- m_axis_tdata_o  out  8  payload byte.
- m_axis_tvalid_o  out  1  payload byte valid.
- m_axis_tlast_o  out  1  last payload byte.
- frame_done_o  out  1  one-cycle pulse when frame handling ends.
- frame_ok_o  out  1  qualifies frame_done_o: FCS good, header accepted, no error.
- crc_err_o  out  1  one-cycle pulse on FCS mismatch; feeds status crc_err.
- host_mac_o  out  48  source MAC of the last accepted frame.
- host_ip_o  out  32  source IP of the last accepted frame.
- host_port_o  out  16  source port of the last accepted frame.

Behaviour:
- Reset: all outputs 0, state IDLE, CRC register 0xFFFFFFFF, counters 0.
- No backpressure; tready is absent. The downstream FIFO must absorb 1 byte/cycle and discard on !frame_ok_o.
- FSM states and transitions:
  - IDLE: on rx_dv_i=1 and byte 0x55 -> PREAMBLE. On rx_dv_i=1 and any other byte -> DROP.
  - PREAMBLE: 0x55 stays. 0xD5 (SFD) -> HEADER with byte counter cleared and CRC initialized. Any other byte -> DROP.
  - HEADER: shift 42 bytes into a header register. After byte 42, evaluate acceptance combinationally and register the result.
    - Accept -> PAYLOAD, or TAIL if payload length is 0.
    - Reject -> DROP.
  - Header acceptance rules:
    - eth_type == 0x0800, version_ihl == 0x45, protocol == 0x11.
    - UDP length in 8..MAX_PAYLOAD+8.
    - If check_destination_i: dest MAC == fpga_mac_i or FF:FF:FF:FF:FF:FF; dest IP == fpga_ip_i; dest port == fpga_port_i.
  - PAYLOAD: emit (UDP length − 8) bytes. tvalid is registered, latency 1 cycle from rx_data_i. tlast is set on the final byte. Then -> TAIL.
  - TAIL: consume padding and FCS until rx_dv_i falls, then finalize.
    - CRC register == 0xDEBB20E3 (reflected residue) and no error: frame_ok_o=1, host_* updated.
    - Otherwise crc_err_o pulses if the mismatch is the cause.
    - frame_done_o pulses one cycle after rx_dv_i falls.
  - DROP: ignore bytes until rx_dv_i=0, then frame_done_o with frame_ok_o=0, -> IDLE. No AXIS output in DROP.
- CRC-32:
  - Reflected polynomial 0xEDB88320, byte-parallel, init 0xFFFFFFFF.
  - Covers from the first dest MAC byte through the last FCS byte.
  - Only updated on rx_dv_i=1 in HEADER, PAYLOAD and TAIL.
- rx_er_i=1 in any non-IDLE state marks the frame bad, so frame_ok_o=0. Payload already in progress keeps streaming and tlast is still produced.
- rx_dv_i falls in HEADER -> frame_done_o, frame_ok_o=0, no AXIS output.
- rx_dv_i falls in PAYLOAD (truncated frame):
  - The current byte is emitted with tlast forced to 1.
  - frame_done_o pulses the next cycle with frame_ok_o=0.
- Fewer than 4 bytes in TAIL means a missing FCS and counts as a CRC failure; crc_err_o=1.
- Back-to-back frames: the IPG is at least 1 cycle of rx_dv_i=0, and the finalize cycle must fit in that gap.
- Async reset mid-frame: outputs clear immediately. The rest of the frame is seen as non-preamble data -> DROP until rx_dv_i low.
- Multi-byte fields are big-endian on the wire; header compare uses wire order.

Test Plan:
- Accepted frame: fpga MAC 02:00:00:00:00:01, IP 192.168.1.10, port 5000, check_destination=1. Send 7×0x55, 0xD5, valid header with UDP length 12, payload DE AD BE EF, 14 bytes padding, good FCS.
  - Expect 4 AXIS beats DE AD BE EF with tlast on EF, and frame_done=1, frame_ok=1.
  - Expect host_ip_o to equal the header source IP.
- Same frame with the last FCS byte flipped -> same 4 beats; frame_done=1, frame_ok=0, crc_err=1.
- Dest port 5001:
  - check_destination=1 -> no AXIS beats, frame_ok=0, crc_err=0.
  - check_destination=0 -> payload delivered, frame_ok=1.
- Broadcast dest MAC FF:FF:FF:FF:FF:FF with matching IP/port -> accepted, frame_ok=1.
- rx_dv_i dropped after payload byte 2 of 4 -> beats DE, AD with tlast on AD; frame_done=1, frame_ok=0.
- Error and recovery:
  - eth_type 0x0806 -> DROP, no beats.
  - A following valid frame after a 12-cycle IPG is received correctly.
  - Reset asserted mid-payload, then a fresh valid frame -> only the fresh frame is delivered.
